mc_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the LA32R core. It owns the PC, the instruction register and the state machine that steps each instruction through IF / ID / EXE / MEM / WB. Instruction and data memory are reached over a split request/response handshake, so memory may add any number of wait states. The datapath (decoders, regfile, ALU) stays outside this block and is driven by its strobes.

---
 rtl/mc_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer for the LA32R core: owns PC, IR and memory handshakes.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module mc_seq_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1C00_0000,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [DATA_W-1:0] ir,
  input  logic              dec_is_br,
  input  logic              dec_is_ld,
  input  logic              dec_is_st,
  input  logic              dec_wb,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              exe_en,
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_ID       = 3'd3,
    S_EXE      = 3'd4,
    S_MEM_REQ  = 3'd5,
    S_MEM_WAIT = 3'd6,
    S_WB       = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_ld_data;
  logic              w_inst_req;
  logic              w_data_req;
  logic              w_data_wr;
  logic              w_exe_en;
  logic              w_rf_we;
  logic              w_retire;
  logic              w_ir_load;
  logic              w_ld_load;
  logic [ADDR_W-1:0] w_pc_seq;

  // pc+4 wraps naturally at the top of the address space
  assign w_pc_seq = r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode; memory responses only count in the WAIT states
  always_comb begin
    w_state_nxt = r_state;
    w_inst_req  = 1'b0;
    w_data_req  = 1'b0;
    w_data_wr   = 1'b0;
    w_exe_en    = 1'b0;
    w_rf_we     = 1'b0;
    w_retire    = 1'b0;
    w_ir_load   = 1'b0;
    w_ld_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IF_REQ;
      end
      S_IF_REQ: begin
        w_inst_req = 1'b1;
        if (inst_addr_ok) begin
          w_state_nxt = S_IF_WAIT;
        end else begin
          w_state_nxt = S_IF_REQ;
        end
      end
      S_IF_WAIT: begin
        if (inst_data_ok) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_ID;
        end else begin
          w_state_nxt = S_IF_WAIT;
        end
      end
      S_ID: begin
        if (dec_is_br) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IF_REQ;
        end else begin
          w_state_nxt = S_EXE;
        end
      end
      S_EXE: begin
        w_exe_en = 1'b1;
        if (dec_is_ld || dec_is_st) begin
          w_state_nxt = S_MEM_REQ;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM_REQ: begin
        w_data_req = 1'b1;
        w_data_wr  = dec_is_st & ~dec_is_ld;
        if (data_addr_ok) begin
          w_state_nxt = S_MEM_WAIT;
        end else begin
          w_state_nxt = S_MEM_REQ;
        end
      end
      S_MEM_WAIT: begin
        if (data_data_ok) begin
          if (dec_is_ld) begin
            w_ld_load   = 1'b1;
            w_state_nxt = S_WB;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = S_IF_REQ;
          end
        end else begin
          w_state_nxt = S_MEM_WAIT;
        end
      end
      S_WB: begin
        w_rf_we     = dec_wb;
        w_retire    = 1'b1;
        w_state_nxt = S_IF_REQ;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // PC, instruction register and load-data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= {DATA_W{1'b0}};
      r_ld_data <= {DATA_W{1'b0}};
    end else begin
      if (w_retire) begin
        r_pc <= br_taken ? br_target : w_pc_seq;
      end
      if (w_ir_load) begin
        r_ir <= inst_rdata;
      end
      if (w_ld_load) begin
        r_ld_data <= data_rdata;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  // Active-cycle and retire counters, wrapping at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt  <= {CNT_W{1'b0}};
      r_retire_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_state != S_IDLE) begin
        r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;
`else
  assign cycle_cnt  = {CNT_W{1'b0}};
  assign retire_cnt = {CNT_W{1'b0}};
`endif

  assign inst_req  = w_inst_req;
  assign inst_addr = r_pc;
  assign ir        = r_ir;
  assign exe_en    = w_exe_en;
  assign data_req  = w_data_req;
  assign data_wr   = w_data_wr;
  assign ld_data   = r_ld_data;
  assign rf_we     = w_rf_we;
  assign pc        = r_pc;
  assign retire    = w_retire;
  assign state     = r_state;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: the driver pushes one expectation per instruction,
// a negedge monitor pops and compares it on every retire pulse.
module tb_mc_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] ir;
  logic        dec_is_br;
  logic        dec_is_ld;
  logic        dec_is_st;
  logic        dec_wb;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exe_en;
  logic        data_req;
  logic        data_wr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  mc_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .ir(ir),
    .dec_is_br(dec_is_br), .dec_is_ld(dec_is_ld), .dec_is_st(dec_is_st), .dec_wb(dec_wb),
    .br_taken(br_taken), .br_target(br_target), .exe_en(exe_en),
    .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .ld_data(ld_data),
    .rf_we(rf_we), .pc(pc), .retire(retire), .state(state),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    int          exe;
    int          rf;
    logic        dreq;
    logic        dwr;
    logic [31:0] ld;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Monitor state, owned by the monitor process only
  int          mon_lat;
  int          mon_exe;
  int          mon_rf;
  logic        mon_fseen;
  logic [31:0] mon_faddr;
  logic        mon_dreq;
  logic        mon_dwr;
  exp_t        mon_e;

  task automatic mon_clear();
    mon_lat   = 0;
    mon_exe   = 0;
    mon_rf    = 0;
    mon_fseen = 1'b0;
    mon_faddr = 32'h0;
    mon_dreq  = 1'b0;
    mon_dwr   = 1'b0;
  endtask

  // Monitor: observe away from the clock edge and settle each retire against the scoreboard
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      mon_clear();
    end else begin
      if (state != 3'd0) mon_lat++;
      if (inst_req && !mon_fseen) begin
        mon_fseen = 1'b1;
        mon_faddr = inst_addr;
      end
      if (exe_en) mon_exe++;
      if (rf_we) mon_rf++;
      if (data_req) begin
        mon_dreq = 1'b1;
        mon_dwr  = data_wr;
      end
      if (retire) begin
        if (sb.size() == 0) begin
          timeout("unexpected_retire");
        end else begin
          mon_e = sb.pop_front();
          chk("fetch_addr", mon_faddr, mon_e.pc);
          chk("retire_pc", pc, mon_e.pc);
          chk("ir", ir, mon_e.ir);
          chk("exe_en_cycles", 32'(mon_exe), 32'(mon_e.exe));
          chk("rf_we_cycles", 32'(mon_rf), 32'(mon_e.rf));
          chk("data_req_seen", {31'd0, mon_dreq}, {31'd0, mon_e.dreq});
          chk("data_wr", {31'd0, mon_dwr}, {31'd0, mon_e.dwr});
          chk("ld_data", ld_data, mon_e.ld);
          chk("latency", 32'(mon_lat), 32'(mon_e.lat));
        end
        mon_clear();
      end
    end
  end

  // Request/response handshake with aw cycles before addr_ok and dw cycles before data_ok
  task automatic hs(input bit d, input int aw, input int dw, input logic [31:0] rd);
    int n;
    n = 0;
    while (!(d ? data_req : inst_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout(d ? "data_req_wait" : "inst_req_wait");
    repeat (aw) @(negedge clk);
    if (d) data_addr_ok = 1'b1; else inst_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    inst_addr_ok = 1'b0;
    repeat (dw) @(negedge clk);
    if (d) begin
      data_data_ok = 1'b1;
      data_rdata   = rd;
    end else begin
      inst_data_ok = 1'b1;
      inst_rdata   = rd;
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    inst_data_ok = 1'b0;
  endtask

  task automatic wait_if_req();
    int n;
    n = 0;
    while (state != 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("if_req_wait");
  endtask

  task automatic do_instr(input logic br, input logic ld, input logic st, input logic wb,
                          input logic bt, input logic [31:0] tgt, input logic [31:0] word,
                          input logic [31:0] rd, input int iaw, input int idw,
                          input int daw, input int ddw, input int lat);
    exp_t e;
    logic mem;
    logic wbpath;
    dec_is_br = br;
    dec_is_ld = ld;
    dec_is_st = st;
    dec_wb    = wb;
    br_taken  = bt;
    br_target = tgt;
    mem    = !br && (ld || st);
    wbpath = !br && (ld || !st);
    if (mem && ld) m_ld = rd;
    e.pc   = m_pc;
    e.ir   = word;
    e.exe  = br ? 0 : 1;
    e.rf   = (wbpath && wb) ? 1 : 0;
    e.dreq = mem;
    e.dwr  = mem && st && !ld;
    e.ld   = m_ld;
    e.lat  = lat;
    sb.push_back(e);
    m_pc = bt ? tgt : m_pc + 32'd4;
    hs(1'b0, iaw, idw, word);
    if (mem) hs(1'b1, daw, ddw, rd);
    wait_if_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ret;
    reset = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    dec_is_br = 1'b0; dec_is_ld = 1'b0; dec_is_st = 1'b0; dec_wb = 1'b0;
    br_taken = 1'b0; br_target = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    m_pc = RST_PC;
    m_ld = 32'h0;

    // Reset values
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_strobes", {26'd0, inst_req, data_req, data_wr, exe_en, rf_we, retire}, 32'h0);
    chk("rst_cycle_cnt", cycle_cnt, 32'h0);
    chk("rst_retire_cnt", retire_cnt, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_after_release", {29'd0, state}, 32'd0);
    @(negedge clk);
    chk("if_req_after_idle", {29'd0, state}, 32'd1);
    chk("first_inst_addr", inst_addr, RST_PC);

    //        br    ld    st    wb    bt    target        word          rdata         iaw idw daw ddw lat
    do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0010_0C84, 32'h0,         0, 0, 0, 0, 5);
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_0100, 32'h5800_0400, 32'h0,         0, 0, 0, 0, 3);
    do_instr(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h2880_0085, 32'hDEAD_BEEF, 0, 0, 2, 3, 12);
    do_instr(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         32'h2880_1086, 32'h0BAD_F00D, 0, 0, 0, 0, 7);
    do_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h2980_0087, 32'h0,         0, 0, 1, 0, 7);
    do_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h5C00_0800, 32'h0,         0, 0, 0, 0, 3);
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h5800_0C00, 32'h0,         0, 0, 0, 0, 3);
    do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0010_1088, 32'h0,         1, 2, 0, 0, 8);
    chk("pc_after_wrap", pc, 32'h0000_0004);

    // Abort a load in MEM_WAIT, then present a stray response after release
    dec_is_br = 1'b0; dec_is_ld = 1'b1; dec_is_st = 1'b0; dec_wb = 1'b1; br_taken = 1'b0;
    hs(1'b0, 0, 0, 32'h2880_0089);
    n = 0;
    while (!data_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("abort_data_req_wait");
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("abort_in_mem_wait", {29'd0, state}, 32'd6);
    reset = 1'b1;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_pc", pc, RST_PC);
    chk("abort_ld_data", ld_data, 32'h0);
    chk("abort_strobes", {26'd0, inst_req, data_req, data_wr, exe_en, rf_we, retire}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h1234_5678;
    #1;
    chk("stray_idle_state", {29'd0, state}, 32'd0);
    chk("stray_idle_retire", {31'd0, retire}, 32'd0);
    @(negedge clk);
    #1;
    chk("stray_if_state", {29'd0, state}, 32'd1);
    chk("stray_if_retire", {31'd0, retire}, 32'd0);
    chk("stray_ld_data", ld_data, 32'h0);
    chk("stray_pc", pc, RST_PC);
    data_data_ok = 1'b0;
    m_pc = RST_PC;
    m_ld = 32'h0;

    // Ten back-to-back not-taken branches from reset
    for (int i = 0; i < 10; i++) begin
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5800_0000 + 32'(i), 32'h0, 0, 0, 0, 0, 3);
    end
`ifdef PERF_CNT_EN
    exp_cyc = 32'd30;
    exp_ret = 32'd10;
`else
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
`endif
    chk("cycle_cnt", cycle_cnt, exp_cyc);
    chk("retire_cnt", retire_cnt, exp_ret);
    chk("pc_after_branches", pc, 32'h1C00_0028);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
